// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between fetch (i_*) and data (d_*) ports with one-cycle read return.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is data priority with a fetch wait bound.
module mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDR     = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [ADDR-1:0]  i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic [3:0]       d_we,
  input  logic [ADDR-1:0]  d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             stall_f,
  output logic             stall_m,
  output logic             m_en,
  output logic [3:0]       m_we,
  output logic [ADDR-1:0]  m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_INSTR = 2'd1,
    RESP_DATA  = 2'd2
  } resp_t;

  resp_t            r_respOwn;
  resp_t            w_respOwnNext;
  logic             w_iGnt;
  logic             w_dGnt;
  logic [WIDTH-1:0] r_iHold;
  logic [WIDTH-1:0] r_dHold;
  logic             w_iRvalid;
  logic             w_dRvalid;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {
    LAST_INSTR = 1'b0,
    LAST_DATA  = 1'b1
  } last_t;

  last_t r_lastGnt;
  last_t w_lastGntNext;

  // On a conflict the port that did not win last time takes this cycle.
  always_comb begin
    w_iGnt = 1'b0;
    w_dGnt = 1'b0;
    if (i_req && d_req) begin
      if (r_lastGnt == LAST_DATA) w_iGnt = 1'b1;
      else                        w_dGnt = 1'b1;
    end else begin
      w_iGnt = i_req;
      w_dGnt = d_req;
    end
  end

  always_comb begin
    w_lastGntNext = r_lastGnt;
    if (w_iGnt)      w_lastGntNext = LAST_INSTR;
    else if (w_dGnt) w_lastGntNext = LAST_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) r_lastGnt <= LAST_DATA;
    else       r_lastGnt <= w_lastGntNext;
  end
`else
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MaxWaitC = CW'(MAX_WAIT);

  logic [CW-1:0] r_waitCnt;
  logic [CW-1:0] w_waitCntNext;

  // Data wins conflicts until fetch has been denied MAX_WAIT cycles in a row.
  always_comb begin
    w_iGnt = 1'b0;
    w_dGnt = 1'b0;
    if (i_req && d_req) begin
      if (r_waitCnt == MaxWaitC) w_iGnt = 1'b1;
      else                       w_dGnt = 1'b1;
    end else begin
      w_iGnt = i_req;
      w_dGnt = d_req;
    end
  end

  always_comb begin
    w_waitCntNext = r_waitCnt;
    if (!i_req || w_iGnt)          w_waitCntNext = '0;
    else if (r_waitCnt != MaxWaitC) w_waitCntNext = r_waitCnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_waitCnt <= '0;
    else       r_waitCnt <= w_waitCntNext;
  end
`endif

  assign i_gnt   = w_iGnt;
  assign d_gnt   = w_dGnt;
  assign stall_f = i_req & ~w_iGnt;
  assign stall_m = d_req & ~w_dGnt;

  // Fetches are always reads, so only a data grant can carry strobes or store data.
  always_comb begin
    m_en    = w_iGnt | w_dGnt;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_iGnt) begin
      m_addr = i_addr;
    end else if (w_dGnt) begin
      m_addr  = d_addr;
      m_we    = d_we;
      m_wdata = d_wdata;
    end
  end

  always_comb begin
    w_respOwnNext = RESP_NONE;
    if (w_iGnt)                      w_respOwnNext = RESP_INSTR;
    else if (w_dGnt && d_we == 4'b0) w_respOwnNext = RESP_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) r_respOwn <= RESP_NONE;
    else       r_respOwn <= w_respOwnNext;
  end

  // Gating with reset drops a response that would otherwise land during the reset cycle.
  assign w_iRvalid = (r_respOwn == RESP_INSTR) & ~reset;
  assign w_dRvalid = (r_respOwn == RESP_DATA) & ~reset;
  assign i_rvalid  = w_iRvalid;
  assign d_rvalid  = w_dRvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iHold <= '0;
      r_dHold <= '0;
    end else begin
      if (w_iRvalid) r_iHold <= m_rdata;
      if (w_dRvalid) r_dHold <= m_rdata;
    end
  end

  always_comb begin
    i_rdata = r_iHold;
    d_rdata = r_dHold;
    if (reset) begin
      i_rdata = '0;
      d_rdata = '0;
    end else begin
      if (w_iRvalid) i_rdata = m_rdata;
      if (w_dRvalid) d_rdata = m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; honours ARB_ROUND_ROBIN_EN for the conflict checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [9:0]  i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        stall_f;
  logic        stall_m;
  logic        m_en;
  logic [3:0]  m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic        useMem;
  logic [31:0] forcedRdata;
  logic [31:0] memRdata;
  logic [31:0] mem [0:255];

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(32), .ADDR(10), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .stall_f(stall_f), .stall_m(stall_m),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Simple byte-strobed SRAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (m_we[b]) mem[m_addr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
      end else begin
        memRdata <= mem[m_addr[9:2]];
      end
    end
  end

  assign m_rdata = useMem ? memRdata : forcedRdata;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [9:0] ia, input logic dr,
                               input logic [3:0] dwe, input logic [9:0] da,
                               input logic [31:0] dwd, input logic [31:0] rd);
    i_req       = ir;
    i_addr      = ia;
    d_req       = dr;
    d_we        = dwe;
    d_addr      = da;
    d_wdata     = dwd;
    forcedRdata = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCnt++;
    assert (observed === expected) passCnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Both ports request every cycle from a fresh reset; checks grant order and returning rvalids.
  task automatic runConflict(input int cycles);
    logic expI;
    logic expIPrev;
    expIPrev = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (c != 0) nextCycle();
      applyStimulus(1'b1, 10'h040, 1'b1, 4'h0, 10'h100, 32'h0, 32'h0);
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      expI = (c % 2 == 0);
`else
      expI = (c % 5 == 4);
`endif
      checkOutput($sformatf("conf%0d_i_gnt", c), {31'b0, i_gnt}, {31'b0, expI});
      checkOutput($sformatf("conf%0d_d_gnt", c), {31'b0, d_gnt}, {31'b0, ~expI});
      checkOutput($sformatf("conf%0d_stall_f", c), {31'b0, stall_f}, {31'b0, ~expI});
      checkOutput($sformatf("conf%0d_stall_m", c), {31'b0, stall_m}, {31'b0, expI});
      checkOutput($sformatf("conf%0d_m_addr", c), {22'b0, m_addr}, expI ? 32'h040 : 32'h100);
      if (c == 0) begin
        checkOutput("conf0_i_rvalid", {31'b0, i_rvalid}, 32'h0);
        checkOutput("conf0_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        checkOutput("conf0_i_rdata", i_rdata, 32'h0);
        checkOutput("conf0_d_rdata", d_rdata, 32'h0);
      end else begin
        checkOutput($sformatf("conf%0d_i_rvalid", c), {31'b0, i_rvalid}, {31'b0, expIPrev});
        checkOutput($sformatf("conf%0d_d_rvalid", c), {31'b0, d_rvalid}, {31'b0, ~expIPrev});
      end
      expIPrev = expI;
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    memRdata = 32'h0;
    useMem = 1'b0;
    reset = 1'b1;
    applyStimulus(1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    checkOutput("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    checkOutput("rst_i_rdata", i_rdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    checkOutput("rst_m_en", {31'b0, m_en}, 32'h0);
    checkOutput("rst_stall_f", {31'b0, stall_f}, 32'h0);

    $display("[TB] fetch only");
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      applyStimulus(1'b1, 10'h010, 1'b0, 4'h0, 10'h0, 32'h0, 32'hA0 + c);
      @(negedge clk);
      checkOutput($sformatf("f%0d_i_gnt", c), {31'b0, i_gnt}, 32'h1);
      checkOutput($sformatf("f%0d_m_addr", c), {22'b0, m_addr}, 32'h010);
      checkOutput($sformatf("f%0d_m_we", c), {28'b0, m_we}, 32'h0);
      checkOutput($sformatf("f%0d_m_wdata", c), m_wdata, 32'h0);
      checkOutput($sformatf("f%0d_stall_f", c), {31'b0, stall_f}, 32'h0);
      checkOutput($sformatf("f%0d_i_rvalid", c), {31'b0, i_rvalid}, (c == 0) ? 32'h0 : 32'h1);
      if (c != 0) checkOutput($sformatf("f%0d_i_rdata", c), i_rdata, 32'hA0 + c);
    end

    $display("[TB] hold behaviour");
    nextCycle();
    applyStimulus(1'b0, 10'h010, 1'b0, 4'h0, 10'h0, 32'h0, 32'h12345678);
    @(negedge clk);
    checkOutput("h_deliver_rvalid", {31'b0, i_rvalid}, 32'h1);
    checkOutput("h_deliver_rdata", i_rdata, 32'h12345678);
    checkOutput("h_idle_m_en", {31'b0, m_en}, 32'h0);
    checkOutput("h_idle_m_addr", {22'b0, m_addr}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      applyStimulus(1'b0, 10'h010, 1'b0, 4'h0, 10'h0, 32'h0, 32'h55 + 32'h11 * c);
      @(negedge clk);
      checkOutput($sformatf("h%0d_i_rvalid", c), {31'b0, i_rvalid}, 32'h0);
      checkOutput($sformatf("h%0d_i_rdata", c), i_rdata, 32'h12345678);
    end

    $display("[TB] conflict from reset");
    useMem = 1'b1;
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    runConflict(10);

    $display("[TB] store then load");
    nextCycle();
    applyStimulus(1'b0, 10'h0, 1'b1, 4'hF, 10'h020, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    checkOutput("st_d_gnt", {31'b0, d_gnt}, 32'h1);
    checkOutput("st_m_we", {28'b0, m_we}, 32'hF);
    checkOutput("st_m_addr", {22'b0, m_addr}, 32'h020);
    checkOutput("st_m_wdata", m_wdata, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(1'b0, 10'h0, 1'b1, 4'h0, 10'h020, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("ld_d_gnt", {31'b0, d_gnt}, 32'h1);
    checkOutput("ld_m_we", {28'b0, m_we}, 32'h0);
    checkOutput("st_no_rvalid", {31'b0, d_rvalid}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("ld_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    checkOutput("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    checkOutput("ld_i_rvalid", {31'b0, i_rvalid}, 32'h0);

    $display("[TB] reset mid-operation");
    nextCycle();
    applyStimulus(1'b0, 10'h0, 1'b1, 4'h0, 10'h020, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rm_d_gnt", {31'b0, d_gnt}, 32'h1);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 10'h040, 1'b1, 4'h0, 10'h100, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rm_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    checkOutput("rm_d_rdata", d_rdata, 32'h0);
    checkOutput("rm_i_rdata", i_rdata, 32'h0);
    nextCycle();
    reset = 1'b0;
    runConflict(6);

    $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one synchronous unified instruction/data SRAM between the pipeline's fetch port and its memory-stage data port. It sits between the datapath's imem/dmem interfaces and the physical memory. It grants at most one access per cycle, routes the one-cycle-latency read data back to the owner, and produces stall signals for the fetch and memory stages. It bounds instruction-fetch starvation with a wait counter.

## Interface
- WIDTH, 32, data word width
- ADDR, 10, memory address width (byte address, passed through unmodified)
- MAX_WAIT, 4, max consecutive cycles fetch may be denied while requesting; legal range ≥1

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until granted
- i_addr  in  ADDR  fetch address
- i_gnt  out  1  fetch granted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  WIDTH  fetch read data
- d_req  in  1  data request; held with address/data/strobe stable until granted
- d_we  in  4  byte write strobes; 0 = read
- d_addr  in  ADDR  data address
- d_wdata  in  WIDTH  store data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  data read valid (reads only)
- d_rdata  out  WIDTH  data read data
- stall_f  out  1  i_req & ~i_gnt
- stall_m  out  1  d_req & ~d_gnt
- m_en  out  1  memory access enable
- m_we  out  4  memory byte write strobes
- m_addr  out  ADDR  memory address
- m_wdata  out  WIDTH  memory write data
- m_rdata  in  WIDTH  memory read data, valid one cycle after m_en with m_we==0

## Operation
- Grant decision is combinational from requests and registered state. At most one of i_gnt/d_gnt is high.
- Only one requester active: grant it.
- Both requesting (default policy): grant data unless wait_cnt == MAX_WAIT, then grant fetch.
- wait_cnt width is $clog2(MAX_WAIT+1).
  - Increments (saturating at MAX_WAIT) each cycle i_req & ~i_gnt.
  - Clears when i_gnt or ~i_req.
- Granted requester drives m_addr/m_wdata/m_we. m_en = i_gnt | d_gnt.
  - Fetch grant forces m_we=0 and m_wdata=0.
  - No grant: m_en=0, m_we=0, m_addr=0, m_wdata=0.
- Response owner register resp_own ∈ {NONE, INSTR, DATA} is loaded every cycle:
  - INSTR on i_gnt.
  - DATA on d_gnt with d_we==0.
  - NONE otherwise, including data writes.
- i_rvalid = (resp_own==INSTR); d_rvalid = (resp_own==DATA).
- i_rdata/d_rdata equal m_rdata while their rvalid is high. Otherwise they hold the last delivered word from a per-port hold register, updated on rvalid.
- Writes complete in the grant cycle; no response pulse.

## Timing
- Grant latency 0 cycles: gnt is asserted in the same cycle as req if it wins.
- Read data latency 1 cycle: rvalid is asserted in cycle N+1 for a grant in cycle N.
- Back-to-back grants are allowed every cycle, in any mix of ports.
- Reset values: wait_cnt=0, resp_own=NONE, hold registers=0, last_gnt=DATA. Therefore rvalids=0, rdatas=0, and gnts/stalls follow requests combinationally.
- Reset asserted in the cycle after a grant drops that response: no rvalid in the following cycle.
- Request deasserted while stalled: no grant, wait_cnt clears. No internal request latching.
- Worst-case fetch wait under continuous data traffic is MAX_WAIT cycles, then 1 fetch grant.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Conflicts are resolved round-robin via register last_gnt (updated on every grant); the port not granted last wins.
  - wait_cnt and MAX_WAIT are unused.
- ARB_ROUND_ROBIN_EN undefined: fixed data priority with the wait_cnt starvation bound above.

## Test plan
- Fetch only: i_req=1, i_addr=0x010 for 3 cycles, m_rdata=0xA0+cycle.
  - Expect i_gnt=1 each cycle, m_addr=0x010, m_we=0.
  - Expect i_rvalid=1 from cycle 1, i_rdata=m_rdata. stall_f=0 throughout.
- Conflict, default build, MAX_WAIT=4: i_req and d_req (read, d_addr=0x100) held high from reset.
  - Expect d_gnt in cycles 0-3 and i_gnt in cycle 4 with m_addr=i_addr.
  - Expect stall_f=1 in cycles 0-3 and stall_m=1 in cycle 4. The pattern then repeats.
- Store then load: d_we=4'b1111, d_addr=0x20, d_wdata=0xDEADBEEF, then d_we=0 at the same address.
  - Store: m_we=4'hF, no d_rvalid.
  - Load: d_rvalid next cycle with d_rdata=0xDEADBEEF.
- Hold behaviour: after an i_rvalid delivering 0x12345678, i_req=0 for 3 cycles while m_rdata changes. Expect i_rdata stays 0x12345678 and i_rvalid=0.
- Reset mid-operation: d_req read granted in cycle N, reset=1 in cycle N+1. Expect d_rvalid=0 in N+1, all rdata=0, wait_cnt=0.
- ARB_ROUND_ROBIN_EN build: both ports requesting continuously from reset. Expect grants alternating I, D, I, D starting with I (last_gnt resets to DATA).
